// File: rtl/alu_sequencer.sv
// Multi-cycle control sequencer for the ALU datapath. It walks one instruction
// through operand load, execute and write-back, and routes mul/div results to HI/LO.
module alu_sequencer #(
  parameter int MULDIV_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] opcode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic [3:0] rc,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] alu_op,
  output logic       reg_out_en,
  output logic [3:0] reg_out_sel,
  output logic       y_in,
  output logic       z_in,
  output logic       zlo_out,
  output logic       zhi_out,
  output logic       reg_in_en,
  output logic [3:0] reg_in_sel,
  output logic       lo_in,
  output logic       hi_in
);

  localparam logic [3:0] WAIT_CNT = 4'(MULDIV_WAIT);

  typedef enum logic [2:0] {IDLE, LOAD_Y, EXEC, WB_LO, WB_HI} state_t;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [4:0] op_q;
  logic [3:0] ra_q, rb_q, rc_q;
  logic       capture, done_d, err_d, muldiv;

  function automatic logic is_legal(input logic [4:0] op);
    return ((op >= 5'd1) && (op <= 5'd11)) || (op == 5'd14) || (op == 5'd15);
  endfunction

  assign muldiv = (op_q == 5'd3) || (op_q == 5'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      op_q  <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      done  <= done_d;
      err   <= err_d;
      if (capture) begin
        op_q <= opcode;
        ra_q <= ra;
        rb_q <= rb;
        rc_q <= rc;
      end
    end
  end

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    capture     = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    busy        = (state != IDLE);
    alu_op      = 5'b00000;
    reg_out_en  = 1'b0;
    reg_out_sel = '0;
    y_in        = 1'b0;
    z_in        = 1'b0;
    zlo_out     = 1'b0;
    zhi_out     = 1'b0;
    reg_in_en   = 1'b0;
    reg_in_sel  = '0;
    lo_in       = 1'b0;
    hi_in       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_legal(opcode)) begin
            capture = 1'b1;
            state_d = LOAD_Y;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD_Y: begin
        reg_out_en  = 1'b1;
        reg_out_sel = rb_q;
        y_in        = 1'b1;
        // Arm the down-counter so EXEC lasts cnt+1 cycles.
        cnt_d       = muldiv ? WAIT_CNT : 4'd0;
        state_d     = EXEC;
      end
      EXEC: begin
        reg_out_en  = 1'b1;
        reg_out_sel = ra_q;
        alu_op      = op_q;
        if (cnt == 4'd0) begin
          z_in    = 1'b1;
          state_d = WB_LO;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      WB_LO: begin
        zlo_out = 1'b1;
        if (muldiv) begin
          lo_in   = 1'b1;
          state_d = WB_HI;
        end else begin
          reg_in_en  = 1'b1;
          reg_in_sel = rc_q;
          done_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      WB_HI: begin
        zhi_out = 1'b1;
        hi_in   = 1'b1;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
